// File: rtl/decoder24_pkg.sv
// ---------------------------------------------------------------------------
// decoder24_pkg
// Shared definitions for the registered 2-to-4 decoder:
//   - buffer geometry (depth, pointer and count widths, entry width)
//   - field offsets inside a buffered entry {en, code}
//   - onehot4(): reference decode of one entry into a one-hot word
// ---------------------------------------------------------------------------
package decoder24_pkg;

  localparam int DEPTH    = 2;
  localparam int PTR_W    = 1;
  localparam int CNT_BITS = 2;
  localparam int ENTRY_W  = 3;

  // Entry layout: bit 2 = enable, bits 1:0 = code
  localparam int EN_BIT   = 2;
  localparam int CODE_LSB = 0;

  // Decode an {en, code} pair: enabled gives 1 << code, disabled gives zero.
  function automatic logic [3:0] onehot4(input logic en, input logic [1:0] code);
    logic [3:0] w_word;
    w_word = 4'b0000;
    if (en) begin
      w_word = 4'b0001 << code;
    end
    return w_word;
  endfunction

endpackage

// File: rtl/decoder24_core.sv
// ---------------------------------------------------------------------------
// decoder24_core
// Purely combinational 2-to-4 decode of one buffered entry.
// Ports:
//   i_en    enable captured with the code; 0 forces an all-zero word
//   i_code  2-bit code (bit1 <-> encoder o1, bit0 <-> encoder o0)
//   o_y     one-hot word when enabled, 4'b0000 otherwise
// ---------------------------------------------------------------------------
module decoder24_core (
  input  logic       i_en,
  input  logic [1:0] i_code,
  output logic [3:0] o_y
);

  always_comb begin
    o_y = 4'b0000;
    if (i_en) begin
      case (i_code)
        2'b00:   o_y = 4'b0001;
        2'b01:   o_y = 4'b0010;
        2'b10:   o_y = 4'b0100;
        default: o_y = 4'b1000;
      endcase
    end
  end

endmodule

// File: rtl/decoder24_pipe.sv
// ---------------------------------------------------------------------------
// decoder24_pipe
// Registered 2-to-4 decoder behind a 2-entry FIFO, with per-output
// saturating hit counters.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_code, in_en captured on push
//   out_valid/out_ready   downstream handshake; y is the decoded head entry
//   clr_cnt               synchronous clear of all hit counters
//   cnt0..cnt3            words delivered with y[k] high (saturating)
// ---------------------------------------------------------------------------
module decoder24_pipe #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       y,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  import decoder24_pkg::*;

  localparam logic [CNT_BITS-1:0] FULL    = CNT_BITS'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [ENTRY_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_W-1:0]    r_cnt [4];

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [3:0]         w_core_y;

  // Handshake flags come only from the registered count.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Decode stage: head entry into the combinational core.
  assign w_head = r_mem[r_rptr];

  decoder24_core u_core (
    .i_en   (w_head[EN_BIT]),
    .i_code (w_head[CODE_LSB +: 2]),
    .o_y    (w_core_y)
  );

  // An empty buffer may hold stale or uninitialised entries, so mask them.
  assign y = out_valid ? w_core_y : 4'b0000;

  // Buffer storage stage: data slots carry no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_en, in_code};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Hit counter stage: clear beats a same-edge increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (w_pop) begin
      for (int k = 0; k < 4; k++) begin
        if (y[k]) begin
          r_cnt[k] <= sat_inc(r_cnt[k]);
        end
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];

endmodule

// File: tb/tb_decoder24_pipe.sv
// ---------------------------------------------------------------------------
// tb_decoder24_pipe
// Bench for decoder24_pipe (CNT_W=3 so saturation is reachable).
// A queue-based model tracks buffered entries and hit counts; a negedge
// process compares every output against it each cycle. Directed scenarios
// add literal expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_decoder24_pipe;
  import decoder24_pkg::*;

  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_code = 2'b00;
  logic             in_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       y;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  int tests = 0;
  int fails = 0;

  decoder24_pipe #(.CNT_W(CNT_W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .clr_cnt   (clr_cnt),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 4-to-2 encoder used for the round-trip check.
  function automatic logic [1:0] encoder42(input logic [3:0] w);
    return {w[3] | w[2], w[3] | w[1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model + compare ----------------
  logic [2:0] q[$];
  int         mcnt [4];
  bit         model_ok = 0;
  bit         hold_prev = 0;
  logic [3:0] prev_y = 4'b0;

  always @(negedge clk) begin
    logic [3:0] exp_y;
    logic [3:0] w;
    bit         m_push, m_pop;
    if (model_ok) begin
      exp_y = (q.size() != 0) ? onehot4(q[0][2], q[0][1:0]) : 4'b0000;
      check("in_ready",  32'(in_ready),  32'(q.size() != 2));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("y",         32'(y),         32'(exp_y));
      check("cnt0",      32'(cnt0),      32'(mcnt[0]));
      check("cnt1",      32'(cnt1),      32'(mcnt[1]));
      check("cnt2",      32'(cnt2),      32'(mcnt[2]));
      check("cnt3",      32'(cnt3),      32'(mcnt[3]));
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_y",     32'(y),         32'(prev_y));
      end
    end
    hold_prev = rst_n && out_valid && !out_ready;
    prev_y    = y;
    // Advance the model to the state after the coming rising edge.
    if (!rst_n) begin
      q.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
      model_ok = 1;
    end else if (model_ok) begin
      m_push = in_valid && (q.size() < 2);
      m_pop  = out_ready && (q.size() > 0);
      if (m_pop) begin
        w = onehot4(q[0][2], q[0][1:0]);
        for (int k = 0; k < 4; k++)
          if (w[k] && mcnt[k] < CMAX) mcnt[k]++;
        void'(q.pop_front());
      end
      if (clr_cnt) for (int k = 0; k < 4; k++) mcnt[k] = 0;
      if (m_push) q.push_back({in_en, in_code});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Pin the reference decode with literal values.
    check("onehot_00", 32'(onehot4(1'b1, 2'b00)), 32'h1);
    check("onehot_10", 32'(onehot4(1'b1, 2'b10)), 32'h4);
    check("onehot_11", 32'(onehot4(1'b1, 2'b11)), 32'h8);
    check("onehot_en0", 32'(onehot4(1'b0, 2'b11)), 32'h0);

    // Reset then single transfer
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_y",     32'(y),         32'(0));
    check("rst_ready", 32'(in_ready),  32'(1));
    check("rst_cnt",   32'({cnt0, cnt1, cnt2, cnt3}), 32'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = 2'b10; in_en = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'(1));
    check("t1_y",     32'(y),         32'h4);
    tick();
    check("t1_cnt2",  32'(cnt2), 32'(1));
    check("t1_other", 32'({cnt0, cnt1, cnt3}), 32'(0));

    // Backpressure fill
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 2'b11; in_en = 1'b1;
    tick();
    in_code = 2'b01;
    tick();
    check("bp_ready", 32'(in_ready), 32'(0));
    in_code = 2'b00;
    tick(); tick();
    check("bp_hold_y", 32'(y), 32'h8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_first", 32'(y), 32'h8);
    tick();
    check("bp_second", 32'(y), 32'h2);
    tick();
    check("bp_cnt3",  32'(cnt3), 32'(1));
    check("bp_cnt1",  32'(cnt1), 32'(1));
    check("bp_empty", 32'(out_valid), 32'(0));

    // Enable low
    in_valid = 1'b1; in_code = 2'b11; in_en = 1'b0;
    tick();
    in_valid = 1'b0;
    check("en0_valid", 32'(out_valid), 32'(1));
    check("en0_y",     32'(y),         32'(0));
    tick();
    check("en0_cnts", 32'({cnt0, cnt1, cnt2, cnt3}), 32'({3'd0, 3'd1, 3'd1, 3'd1}));

    // Streaming at full throughput
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_all", 32'({cnt0, cnt1, cnt2, cnt3}), 32'(0));
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_en = 1'b1; in_code = 2'(i % 4);
      tick();
      check("st_valid", 32'(out_valid), 32'(1));
      check("st_ready", 32'(in_ready),  32'(1));
      check("st_round", 32'(encoder42(y)), 32'(i % 4));
    end
    in_valid = 1'b0;
    tick();
    check("st_cnts", 32'({cnt0, cnt1, cnt2, cnt3}), 32'({3'd4, 3'd4, 3'd4, 3'd4}));

    // Saturation and clear
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_en = 1'b1; in_code = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("sat_cnt0", 32'(cnt0), 32'(7));
    in_valid = 1'b1; in_code = 2'b00;
    tick();
    in_valid = 1'b0;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_win", 32'(cnt0), 32'(0));

    // Reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; in_en = 1'b1; in_code = 2'b01;
    tick();
    in_code = 2'b10;
    tick();
    in_valid = 1'b0;
    check("mr_full", 32'(in_ready), 32'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_valid", 32'(out_valid), 32'(0));
    check("mr_y",     32'(y),         32'(0));
    check("mr_ready", 32'(in_ready),  32'(1));
    check("mr_cnt",   32'({cnt0, cnt1, cnt2, cnt3}), 32'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_nostale", 32'(out_valid), 32'(0));
    end

    // Randomized phase; held inputs follow the upstream stability rule.
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_code  = 2'($urandom_range(0, 3));
        in_en    = ($urandom_range(0, 9) != 0);
      end
      out_ready = ($urandom_range(0, 99) < 55);
      clr_cnt   = ($urandom_range(0, 99) < 2);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
